// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, DPI-backed memory between the IFU (read-only)
// and the LSU (read/write). Only one transaction is in flight at a time, and
// each transaction produces exactly one men pulse. A transaction runs
// IDLE -> [WAIT] -> ACCESS -> RESP -> IDLE.
//
// Optional build macro:
//   MEM_ARB_RR_EN  round-robin arbitration between IFU and LSU. When it is not
//                  defined, the LSU has fixed priority over the IFU.
module mem_port_arbiter #(
    parameter int AW        = 64,
    parameter int DW        = 64,
    parameter int MEM_DELAY = 0
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_req_addr,
    output logic          ifu_rsp_valid,
    input  logic          ifu_rsp_ready,
    output logic [DW-1:0] ifu_rsp_data,

    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic          lsu_req_wen,
    input  logic [AW-1:0] lsu_req_addr,
    input  logic [DW-1:0] lsu_req_wdata,
    input  logic [7:0]    lsu_req_wmask,
    output logic          lsu_rsp_valid,
    input  logic          lsu_rsp_ready,
    output logic [DW-1:0] lsu_rsp_data,

    output logic          men,
    output logic          mwen,
    output logic [AW-1:0] raddr,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic [7:0]    wmask,
    input  logic [DW-1:0] rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // Wait counter reload value; MEM_DELAY is limited to 0..15.
    localparam logic [3:0] DELAY_CNT = 4'(MEM_DELAY);

    state_t        state_q, state_nx;
    logic [3:0]    cnt_q, cnt_nx;

    // Latched transaction. owner_q is 1 for an LSU transaction.
    logic          owner_q;
    logic          wen_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [7:0]    wmask_q;
    logic [DW-1:0] rsp_data_q;

    logic          grant_ifu;
    logic          grant_lsu;
    logic          req_hs;

`ifdef MEM_ARB_RR_EN
    // Requester granted most recently: 1 = LSU, 0 = IFU.
    logic          last_grant_q;

    // Round-robin: on a tie, grant the requester that was not granted last.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (ifu_req_valid && lsu_req_valid) begin
            grant_lsu = ~last_grant_q;
            grant_ifu = last_grant_q;
        end else begin
            grant_lsu = lsu_req_valid;
            grant_ifu = ifu_req_valid;
        end
    end

    // Record the winner of every request handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b0;
        end else if (req_hs) begin
            last_grant_q <= lsu_req_ready;
        end
    end
`else
    // Fixed priority: the LSU wins over the IFU.
    always_comb begin
        grant_lsu = lsu_req_valid;
        grant_ifu = ifu_req_valid & ~lsu_req_valid;
    end
`endif

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
        end
    end

    // Next-state logic plus all handshake and memory-enable outputs.
    always_comb begin
        state_nx      = state_q;
        cnt_nx        = cnt_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        men           = 1'b0;
        mwen          = 1'b0;
        req_hs        = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Never accept a request in a cycle where reset is high.
                if (!rst) begin
                    ifu_req_ready = grant_ifu;
                    lsu_req_ready = grant_lsu;
                end
                req_hs = ifu_req_ready | lsu_req_ready;
                if (req_hs) begin
                    cnt_nx   = DELAY_CNT;
                    state_nx = (MEM_DELAY == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_nx = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_nx = S_ACCESS;
                end
            end
            S_ACCESS: begin
                men      = 1'b1;
                mwen     = wen_q;
                state_nx = S_RESP;
            end
            S_RESP: begin
                ifu_rsp_valid = ~owner_q;
                lsu_rsp_valid = owner_q;
                if ((owner_q && lsu_rsp_ready) || (!owner_q && ifu_rsp_ready)) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Latch the granted request at handshake and capture the response during ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            if (req_hs) begin
                owner_q <= lsu_req_ready;
                if (lsu_req_ready) begin
                    wen_q   <= lsu_req_wen;
                    addr_q  <= lsu_req_addr;
                    wdata_q <= lsu_req_wdata;
                    wmask_q <= lsu_req_wen ? lsu_req_wmask : 8'h00;
                end else begin
                    wen_q   <= 1'b0;
                    addr_q  <= ifu_req_addr;
                    wdata_q <= '0;
                    wmask_q <= 8'h00;
                end
            end
            if (state_q == S_ACCESS) begin
                rsp_data_q <= wen_q ? '0 : rdata;
            end
        end
    end

    assign raddr        = addr_q;
    assign waddr        = addr_q;
    assign wdata        = wdata_q;
    assign wmask        = wmask_q;
    assign ifu_rsp_data = rsp_data_q;
    assign lsu_rsp_data = rsp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter.
// dut0 uses MEM_DELAY=0 and carries the main traffic. A scoreboard holds the
// expected memory accesses and responses. dut1 uses MEM_DELAY=3 and covers
// wait-state latency and a reset in the middle of a transaction.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_d;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // dut0 signals
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [63:0] ifu_req_addr, ifu_rsp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_ready;
    logic [63:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_data;
    logic [7:0]  lsu_req_wmask;
    logic        men, mwen;
    logic [63:0] raddr, waddr, wdata, rdata;
    logic [7:0]  wmask;

    // dut1 signals (MEM_DELAY = 3, IFU traffic only)
    logic        ifu_req_valid_d, ifu_req_ready_d, ifu_rsp_valid_d, ifu_rsp_ready_d;
    logic [63:0] ifu_req_addr_d, ifu_rsp_data_d;
    logic        lsu_req_valid_d, lsu_req_ready_d, lsu_req_wen_d, lsu_rsp_valid_d, lsu_rsp_ready_d;
    logic [63:0] lsu_req_addr_d, lsu_req_wdata_d, lsu_rsp_data_d;
    logic [7:0]  lsu_req_wmask_d;
    logic        men_d, mwen_d;
    logic [63:0] raddr_d, waddr_d, wdata_d, rdata_d;
    logic [7:0]  wmask_d;

    // Memory model: 8 words, indexed by {addr[12], addr[4:3]}.
    logic [63:0] mem [0:7];
    int          wr_cnt = 0;

    typedef struct {
        bit          o;
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } acc_t;

    acc_t        exp_acc[$];
    logic [63:0] exp_ifu[$];
    logic [63:0] exp_lsu[$];
    int          hs_cyc [2];
    int          rsp_cyc[2];
    bit          exp_last;   // model of the round-robin last grant: 1 = LSU

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.AW(64), .DW(64), .MEM_DELAY(0)) dut0 (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_data(ifu_rsp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_wen(lsu_req_wen),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_data(lsu_rsp_data),
        .men(men), .mwen(mwen), .raddr(raddr), .waddr(waddr), .wdata(wdata), .wmask(wmask),
        .rdata(rdata)
    );

    mem_port_arbiter #(.AW(64), .DW(64), .MEM_DELAY(3)) dut1 (
        .clk(clk), .rst(rst_d),
        .ifu_req_valid(ifu_req_valid_d), .ifu_req_ready(ifu_req_ready_d), .ifu_req_addr(ifu_req_addr_d),
        .ifu_rsp_valid(ifu_rsp_valid_d), .ifu_rsp_ready(ifu_rsp_ready_d), .ifu_rsp_data(ifu_rsp_data_d),
        .lsu_req_valid(lsu_req_valid_d), .lsu_req_ready(lsu_req_ready_d), .lsu_req_wen(lsu_req_wen_d),
        .lsu_req_addr(lsu_req_addr_d), .lsu_req_wdata(lsu_req_wdata_d), .lsu_req_wmask(lsu_req_wmask_d),
        .lsu_rsp_valid(lsu_rsp_valid_d), .lsu_rsp_ready(lsu_rsp_ready_d), .lsu_rsp_data(lsu_rsp_data_d),
        .men(men_d), .mwen(mwen_d), .raddr(raddr_d), .waddr(waddr_d), .wdata(wdata_d), .wmask(wmask_d),
        .rdata(rdata_d)
    );

    assign rdata   = mem[{raddr[12], raddr[4:3]}];
    assign rdata_d = mem[{raddr_d[12], raddr_d[4:3]}];

    // Memory contents and the byte-masked write port (dut0 is the only writer).
    always @(posedge clk) begin
        if (rst) begin
            mem[0] <= 64'h00000413_00000297;
            mem[1] <= 64'h01234567_89ABCDEF;
            mem[2] <= 64'h22222222_22222222;
            mem[3] <= 64'h33333333_33333333;
            mem[4] <= 64'h11111111_11111111;
            mem[5] <= 64'h55555555_55555555;
            mem[6] <= 64'h66666666_66666666;
            mem[7] <= 64'h77777777_77777777;
        end else if (men && mwen) begin
            for (int b = 0; b < 8; b++) begin
                if (wmask[b]) mem[{waddr[12], waddr[4:3]}][b*8 +: 8] <= wdata[b*8 +: 8];
            end
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor for dut0.
    always @(negedge clk) begin
        acc_t        e;
        logic [63:0] d;
        chk("req_ready_onehot0", 64'($onehot0({ifu_req_ready, lsu_req_ready})), 64'd1);
        if (men !== 1'b1) chk("mwen_idle_zero", {63'd0, mwen}, 64'd0);
        if (men === 1'b1) begin
            if (exp_acc.size() == 0) begin
                chk("unexpected_men", 64'd1, 64'd0);
            end else begin
                e = exp_acc.pop_front();
                chk("acc_raddr", raddr, e.addr);
                chk("acc_waddr", waddr, e.addr);
                chk("acc_mwen", {63'd0, mwen}, {63'd0, e.wen});
                chk("acc_wmask", {56'd0, wmask}, {56'd0, e.wmask});
                if (e.wen) chk("acc_wdata", wdata, e.wdata);
            end
        end
        if (ifu_rsp_valid === 1'b1 && ifu_rsp_ready === 1'b1) begin
            if (exp_ifu.size() == 0) chk("unexpected_ifu_rsp", 64'd1, 64'd0);
            else begin
                d = exp_ifu.pop_front();
                chk("ifu_rsp_data", ifu_rsp_data, d);
            end
        end
        if (lsu_rsp_valid === 1'b1 && lsu_rsp_ready === 1'b1) begin
            if (exp_lsu.size() == 0) chk("unexpected_lsu_rsp", 64'd1, 64'd0);
            else begin
                d = exp_lsu.pop_front();
                chk("lsu_rsp_data", lsu_rsp_data, d);
            end
        end
    end

    task automatic expect_txn(input bit o, input logic wen, input logic [63:0] addr,
                              input logic [63:0] wd, input logic [7:0] wm, input logic [63:0] rsp);
        acc_t e;
        e.o = o; e.wen = wen; e.addr = addr; e.wdata = wd; e.wmask = wen ? wm : 8'h00;
        exp_acc.push_back(e);
        if (o) exp_lsu.push_back(rsp);
        else   exp_ifu.push_back(rsp);
    endtask

    // Drive one request on dut0 and check handshake timing; the response is held off for `hold` cycles.
    task automatic drive(input bit o, input logic wen, input logic [63:0] addr, input logic [63:0] wd,
                         input logic [7:0] wm, input logic [63:0] exp, input int hold);
        int k;
        bit ok;
        @(posedge clk); #1;
        if (o) begin
            lsu_req_valid = 1'b1; lsu_req_wen = wen; lsu_req_addr = addr;
            lsu_req_wdata = wd; lsu_req_wmask = wm;
            if (hold > 0) lsu_rsp_ready = 1'b0;
        end else begin
            ifu_req_valid = 1'b1; ifu_req_addr = addr;
            if (hold > 0) ifu_rsp_ready = 1'b0;
        end
        ok = 1'b0;
        for (k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if ((o ? lsu_req_ready : ifu_req_ready) === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            chk("req_ready_timeout", 64'd1, 64'd0);
            if (o) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
            return;
        end
        hs_cyc[o] = cyc;
        @(posedge clk); #1;
        // Change the request after the handshake; the latched copy must not follow.
        if (o) begin
            lsu_req_valid = 1'b0; lsu_req_addr = 64'hBAD0_BAD0_BAD0_BAD0;
            lsu_req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; lsu_req_wmask = 8'hFF;
        end else begin
            ifu_req_valid = 1'b0; ifu_req_addr = 64'hBAD0_BAD0_BAD0_BAD0;
        end
        k = 0; ok = 1'b0;
        while (!ok && k < 40) begin
            @(negedge clk); k++;
            if (men === 1'b1) ok = 1'b1;
        end
        chk("men_latency", 64'(k), 64'd1);
        @(negedge clk);
        chk("rsp_valid_latency", {63'd0, (o ? lsu_rsp_valid : ifu_rsp_valid)}, 64'd1);
        rsp_cyc[o] = cyc;
        for (int i = 0; i < hold; i++) begin
            chk("hold_rsp_valid", {63'd0, (o ? lsu_rsp_valid : ifu_rsp_valid)}, 64'd1);
            chk("hold_rsp_data", (o ? lsu_rsp_data : ifu_rsp_data), exp);
            chk("hold_no_men", {63'd0, men}, 64'd0);
            chk("hold_other_ready", {63'd0, (o ? ifu_req_ready : lsu_req_ready)}, 64'd0);
            @(posedge clk); #1;
            if (i == hold - 1) begin
                if (o) lsu_rsp_ready = 1'b1; else ifu_rsp_ready = 1'b1;
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        chk("rsp_valid_drop", {63'd0, (o ? lsu_rsp_valid : ifu_rsp_valid)}, 64'd0);
    endtask

    // IFU and LSU raise their requests in the same cycle; the expected winner is decided by the caller.
    task automatic sim_pair(input bit lsu_first, input logic [63:0] la, input logic [63:0] lexp,
                            input logic [63:0] ia, input logic [63:0] iexp);
        if (lsu_first) begin
            expect_txn(1'b1, 1'b0, la, 64'd0, 8'h00, lexp);
            expect_txn(1'b0, 1'b0, ia, 64'd0, 8'h00, iexp);
        end else begin
            expect_txn(1'b0, 1'b0, ia, 64'd0, 8'h00, iexp);
            expect_txn(1'b1, 1'b0, la, 64'd0, 8'h00, lexp);
        end
        fork
            drive(1'b1, 1'b0, la, 64'd0, 8'h00, lexp, 0);
            drive(1'b0, 1'b0, ia, 64'd0, 8'h00, iexp, 0);
        join
        chk("pair_order", {63'd0, hs_cyc[1] < hs_cyc[0]}, {63'd0, lsu_first});
        chk("pair_total_cycles", 64'(rsp_cyc[lsu_first ? 0 : 1] - hs_cyc[lsu_first ? 1 : 0]), 64'd5);
        exp_last = ~lsu_first;
    endtask

    // One IFU read on dut1, with its wait-state latency checked.
    task automatic d_read(input logic [63:0] addr, input logic [63:0] exp);
        int k;
        bit ok;
        @(posedge clk); #1;
        ifu_req_valid_d = 1'b1; ifu_req_addr_d = addr;
        ok = 1'b0;
        for (k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (ifu_req_ready_d === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            chk("d_req_ready_timeout", 64'd1, 64'd0);
            ifu_req_valid_d = 1'b0;
            return;
        end
        @(posedge clk); #1;
        ifu_req_valid_d = 1'b0;
        k = 0; ok = 1'b0;
        while (!ok && k < 40) begin
            @(negedge clk); k++;
            if (men_d === 1'b1) ok = 1'b1;
        end
        chk("d_men_latency", 64'(k), 64'd4);
        chk("d_raddr", raddr_d, addr);
        chk("d_mwen", {63'd0, mwen_d}, 64'd0);
        @(negedge clk);
        chk("d_rsp_valid", {63'd0, ifu_rsp_valid_d}, 64'd1);
        chk("d_rsp_data", ifu_rsp_data_d, exp);
        @(posedge clk);
        @(negedge clk);
        chk("d_rsp_drop", {63'd0, ifu_rsp_valid_d}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rst_d = 1'b1;
        ifu_req_valid = 1'b0; ifu_req_addr = '0; ifu_rsp_ready = 1'b1;
        lsu_req_valid = 1'b0; lsu_req_wen = 1'b0; lsu_req_addr = '0;
        lsu_req_wdata = '0; lsu_req_wmask = '0; lsu_rsp_ready = 1'b1;
        ifu_req_valid_d = 1'b0; ifu_req_addr_d = '0; ifu_rsp_ready_d = 1'b1;
        lsu_req_valid_d = 1'b0; lsu_req_wen_d = 1'b0; lsu_req_addr_d = '0;
        lsu_req_wdata_d = '0; lsu_req_wmask_d = '0; lsu_rsp_ready_d = 1'b1;
        exp_last = 1'b0;

        // Reset: requests raised while rst is high are not accepted.
        @(posedge clk); #1;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        @(negedge clk);
        chk("rst_ifu_req_ready", {63'd0, ifu_req_ready}, 64'd0);
        chk("rst_lsu_req_ready", {63'd0, lsu_req_ready}, 64'd0);
        chk("rst_men", {63'd0, men}, 64'd0);
        chk("rst_rsp_valid", {62'd0, ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; rst_d = 1'b0;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_rsp_data", ifu_rsp_data, 64'd0);
        chk("post_rst_raddr", raddr, 64'd0);
        chk("post_rst_wmask", {56'd0, wmask}, 64'd0);

        // Both requesters valid straight after reset: the LSU wins in both modes.
        sim_pair(1'b1, 64'h8000_0008, 64'h01234567_89ABCDEF, 64'h8000_0000, 64'h00000413_00000297);

        // IFU read alone; the response is held for 3 cycles.
        expect_txn(1'b0, 1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'h00000413_00000297);
        drive(1'b0, 1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'h00000413_00000297, 3);
        exp_last = 1'b0;

        // LSU write with a partial byte mask.
        expect_txn(1'b1, 1'b1, 64'h8000_1000, 64'hDEADBEEF_CAFEF00D, 8'h0F, 64'd0);
        drive(1'b1, 1'b1, 64'h8000_1000, 64'hDEADBEEF_CAFEF00D, 8'h0F, 64'd0, 0);
        chk("single_write_call", 64'(wr_cnt), 64'd1);
        exp_last = 1'b1;

        // LSU response backpressure for 5 cycles while the IFU is waiting.
        expect_txn(1'b1, 1'b0, 64'h8000_1008, 64'd0, 8'h00, 64'h55555555_55555555);
        expect_txn(1'b0, 1'b0, 64'h8000_1000, 64'd0, 8'h00, 64'h11111111_CAFEF00D);
        fork
            drive(1'b1, 1'b0, 64'h8000_1008, 64'd0, 8'h00, 64'h55555555_55555555, 5);
            begin
                @(posedge clk); @(posedge clk);
                drive(1'b0, 1'b0, 64'h8000_1000, 64'd0, 8'h00, 64'h11111111_CAFEF00D, 0);
            end
        join
        exp_last = 1'b0;

        // A lone LSU read-back of the masked write; afterwards the LSU was granted last.
        expect_txn(1'b1, 1'b0, 64'h8000_1000, 64'd0, 8'h00, 64'h11111111_CAFEF00D);
        drive(1'b1, 1'b0, 64'h8000_1000, 64'd0, 8'h00, 64'h11111111_CAFEF00D, 0);
        exp_last = 1'b1;

        // A second simultaneous pair: with round-robin the IFU goes first this time.
`ifdef MEM_ARB_RR_EN
        sim_pair(~exp_last, 64'h8000_0010, 64'h22222222_22222222, 64'h8000_0018, 64'h33333333_33333333);
`else
        sim_pair(1'b1, 64'h8000_0010, 64'h22222222_22222222, 64'h8000_0018, 64'h33333333_33333333);
`endif

        // dut1 (MEM_DELAY=3): wait-state latency.
        d_read(64'h8000_0008, 64'h01234567_89ABCDEF);

        // dut1: reset while in WAIT drops the transaction.
        @(posedge clk); #1;
        ifu_req_valid_d = 1'b1; ifu_req_addr_d = 64'h8000_0000;
        @(negedge clk);
        chk("d_drop_req_ready", {63'd0, ifu_req_ready_d}, 64'd1);
        @(posedge clk); #1;
        ifu_req_valid_d = 1'b0;
        @(posedge clk); #1;
        rst_d = 1'b1; ifu_req_valid_d = 1'b1;
        @(negedge clk);
        chk("d_rst_req_ready", {63'd0, ifu_req_ready_d}, 64'd0);
        chk("d_rst_men", {63'd0, men_d}, 64'd0);
        @(posedge clk); #1;
        rst_d = 1'b0; ifu_req_valid_d = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("d_dropped_men", {63'd0, men_d}, 64'd0);
            chk("d_dropped_rsp", {63'd0, ifu_rsp_valid_d}, 64'd0);
        end
        d_read(64'h8000_0000, 64'h00000413_00000297);

        repeat (3) @(posedge clk);
        chk("acc_queue_empty", 64'(exp_acc.size()), 64'd0);
        chk("ifu_queue_empty", 64'(exp_ifu.size()), 64'd0);
        chk("lsu_queue_empty", 64'(exp_lsu.size()), 64'd0);
        chk("total_write_calls", 64'(wr_cnt), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
